// File: rtl/bp_be_issue_queue_if.sv
// Bundle of the FE-side and dispatch-side signals of the BE issue queue.
// The queue itself connects through the slave modport, and its driver
// connects through the master modport.
interface bp_be_issue_queue_if #(
   parameter int unsigned vaddr_width_p = 39,
   parameter int unsigned depth_p       = 4,
   parameter int unsigned ecode_width_p = 4
);
   localparam int unsigned cnt_width_lp = $clog2(depth_p + 1);

   // FE side
   logic                      fe_v_i;
   logic                      fe_exc_v_i;
   logic [ecode_width_p-1:0]  fe_exc_code_i;
   logic [vaddr_width_p-1:0]  fe_pc_i;
   logic [31:0]               fe_instr_i;
   logic                      fe_yumi_o;

   // Dispatch side
   logic                      dispatch_v_i;
   logic [vaddr_width_p-1:0]  expected_npc_i;
   logic                      poison_i;
   logic                      flush_i;
   logic                      isd_v_o;
   logic                      isd_poison_o;
   logic [vaddr_width_p-1:0]  isd_pc_o;
   logic [31:0]               isd_instr_o;
   logic                      isd_exc_v_o;
   logic [ecode_width_p-1:0]  isd_exc_code_o;
   logic                      isd_mem_v_o;
   logic                      isd_fence_v_o;
   logic                      isd_irs1_v_o;
   logic                      isd_irs2_v_o;
   logic [63:0]               isd_imm_o;
   logic [cnt_width_lp-1:0]   count_o;

   modport master (
      output fe_v_i, fe_exc_v_i, fe_exc_code_i, fe_pc_i, fe_instr_i,
      output dispatch_v_i, expected_npc_i, poison_i, flush_i,
      input  fe_yumi_o, isd_v_o, isd_poison_o, isd_pc_o, isd_instr_o,
      input  isd_exc_v_o, isd_exc_code_o, isd_mem_v_o, isd_fence_v_o,
      input  isd_irs1_v_o, isd_irs2_v_o, isd_imm_o, count_o
   );

   modport slave (
      input  fe_v_i, fe_exc_v_i, fe_exc_code_i, fe_pc_i, fe_instr_i,
      input  dispatch_v_i, expected_npc_i, poison_i, flush_i,
      output fe_yumi_o, isd_v_o, isd_poison_o, isd_pc_o, isd_instr_o,
      output isd_exc_v_o, isd_exc_code_o, isd_mem_v_o, isd_fence_v_o,
      output isd_irs1_v_o, isd_irs2_v_o, isd_imm_o, count_o
   );
endinterface

// File: rtl/bp_be_issue_queue.sv
// BE issue queue: circular buffer of predecoded FE messages. Predecode is
// done at enqueue; the head is presented for dispatch and marked poisoned on
// a redirect (sticky until flush) or an expected-PC mismatch.
module bp_be_issue_queue #(
   parameter int unsigned vaddr_width_p = 39,
   parameter int unsigned depth_p       = 4,
   parameter int unsigned ecode_width_p = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   bp_be_issue_queue_if.slave    bus_io
);
   localparam int unsigned ptr_width_lp = $clog2(depth_p);
   localparam int unsigned cnt_width_lp = $clog2(depth_p + 1);

   // Entry storage (no reset needed: validity is tracked by the pointers)
   logic [vaddr_width_p-1:0]  r_pc       [depth_p];
   logic [31:0]               r_instr    [depth_p];
   logic                      r_exc_v    [depth_p];
   logic [ecode_width_p-1:0]  r_exc_code [depth_p];
   logic                      r_mem_v    [depth_p];
   logic                      r_fence_v  [depth_p];
   logic                      r_irs1_v   [depth_p];
   logic                      r_irs2_v   [depth_p];
   logic [63:0]               r_imm      [depth_p];

   logic [ptr_width_lp-1:0]   r_rd_ptr;
   logic [ptr_width_lp-1:0]   r_wr_ptr;
   logic [cnt_width_lp-1:0]   r_count;
   logic                      r_poison;

   logic                      w_full;
   logic                      w_empty;
   logic                      w_head_v;
   logic                      w_enq;
   logic                      w_deq;
   logic                      w_npc_mismatch;

   logic [31:0]               w_instr;
   logic [6:0]                w_opcode;
   logic                      w_sfence;
   logic                      w_pd_mem_v;
   logic                      w_pd_fence_v;
   logic                      w_pd_irs1_v;
   logic                      w_pd_irs2_v;
   logic [63:0]               w_pd_imm;

   assign w_full   = (r_count == cnt_width_lp'(depth_p));
   assign w_empty  = (r_count == '0);
   // Head is only meaningful out of reset; keeps every output at 0 during reset
   assign w_head_v = reset_n_i & ~w_empty;
   assign w_deq    = w_head_v & bus_io.dispatch_v_i & ~bus_io.flush_i;
   // A full queue may still accept when the head leaves in the same cycle
   assign w_enq    = reset_n_i & bus_io.fe_v_i & ~bus_io.flush_i & (~w_full | w_deq);

   assign w_instr  = bus_io.fe_instr_i;
   assign w_opcode = w_instr[6:0];
   assign w_sfence = (w_instr[31:25] == 7'b0001001) && (w_instr[14:12] == 3'b000)
                     && (w_instr[11:7] == 5'd0);

   // Predecode of the incoming message; exceptions carry no predecode
   always_comb begin
      w_pd_mem_v   = 1'b0;
      w_pd_fence_v = 1'b0;
      w_pd_irs1_v  = 1'b0;
      w_pd_irs2_v  = 1'b0;
      w_pd_imm     = '0;
      if (!bus_io.fe_exc_v_i) begin
         case (w_opcode)
            7'b0110111, 7'b0010111: begin
               w_pd_imm = {{32{w_instr[31]}}, w_instr[31:12], 12'b0};
            end
            7'b1101111: begin
               w_pd_imm = {{44{w_instr[31]}}, w_instr[19:12], w_instr[20],
                           w_instr[30:21], 1'b0};
            end
            7'b1100011: begin
               w_pd_irs1_v = 1'b1;
               w_pd_irs2_v = 1'b1;
               w_pd_imm    = {{52{w_instr[31]}}, w_instr[7], w_instr[30:25],
                              w_instr[11:8], 1'b0};
            end
            7'b0100011: begin
               w_pd_mem_v  = 1'b1;
               w_pd_irs1_v = 1'b1;
               w_pd_irs2_v = 1'b1;
               w_pd_imm    = {{52{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            7'b0000011: begin
               w_pd_mem_v  = 1'b1;
               w_pd_irs1_v = 1'b1;
               w_pd_imm    = {{52{w_instr[31]}}, w_instr[31:20]};
            end
            7'b1100111, 7'b0010011, 7'b0011011: begin
               w_pd_irs1_v = 1'b1;
               w_pd_imm    = {{52{w_instr[31]}}, w_instr[31:20]};
            end
            7'b1110011: begin
               w_pd_irs1_v  = 1'b1;
               w_pd_fence_v = w_sfence;
               w_pd_imm     = {59'd0, w_instr[19:15]};
            end
            7'b0110011, 7'b0111011: begin
               w_pd_irs1_v = 1'b1;
               w_pd_irs2_v = 1'b1;
            end
            7'b0101111: begin
               w_pd_mem_v  = 1'b1;
               w_pd_irs1_v = 1'b1;
               w_pd_irs2_v = 1'b1;
            end
            7'b0001111: begin
               w_pd_fence_v = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Write the predecoded message into the tail slot
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_pc[r_wr_ptr]       <= bus_io.fe_pc_i;
         r_instr[r_wr_ptr]    <= w_instr;
         r_exc_v[r_wr_ptr]    <= bus_io.fe_exc_v_i;
         r_exc_code[r_wr_ptr] <= bus_io.fe_exc_code_i;
         r_mem_v[r_wr_ptr]    <= w_pd_mem_v;
         r_fence_v[r_wr_ptr]  <= w_pd_fence_v;
         r_irs1_v[r_wr_ptr]   <= w_pd_irs1_v;
         r_irs2_v[r_wr_ptr]   <= w_pd_irs2_v;
         r_imm[r_wr_ptr]      <= w_pd_imm;
      end
   end

   // Pointers, occupancy and sticky poison; flush empties everything
   always_ff @(posedge clk_i) begin
      if (!reset_n_i || bus_io.flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_poison <= 1'b0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + ptr_width_lp'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + ptr_width_lp'(1);
         r_count  <= r_count + cnt_width_lp'(w_enq) - cnt_width_lp'(w_deq);
         r_poison <= r_poison | bus_io.poison_i;
      end
   end

   assign w_npc_mismatch = w_head_v & (r_pc[r_rd_ptr] != bus_io.expected_npc_i);

   assign bus_io.fe_yumi_o      = w_enq;
   assign bus_io.isd_v_o        = w_deq;
   assign bus_io.isd_poison_o   = w_deq & (r_poison | bus_io.poison_i | w_npc_mismatch);
   assign bus_io.isd_pc_o       = w_head_v ? r_pc[r_rd_ptr]       : '0;
   assign bus_io.isd_instr_o    = w_head_v ? r_instr[r_rd_ptr]    : '0;
   assign bus_io.isd_exc_v_o    = w_head_v & r_exc_v[r_rd_ptr];
   assign bus_io.isd_exc_code_o = w_head_v ? r_exc_code[r_rd_ptr] : '0;
   assign bus_io.isd_mem_v_o    = w_head_v & r_mem_v[r_rd_ptr];
   assign bus_io.isd_fence_v_o  = w_head_v & r_fence_v[r_rd_ptr];
   assign bus_io.isd_irs1_v_o   = w_head_v & r_irs1_v[r_rd_ptr];
   assign bus_io.isd_irs2_v_o   = w_head_v & r_irs2_v[r_rd_ptr];
   assign bus_io.isd_imm_o      = w_head_v ? r_imm[r_rd_ptr]      : '0;
   assign bus_io.count_o        = reset_n_i ? r_count : '0;
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue: fill/stall, full-queue streaming across
// pointer wrap, PC-mismatch and sticky poison, flush, mid-run reset, predecode.
module tb_bp_be_issue_queue;
   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   bp_be_issue_queue_if #(.vaddr_width_p(39), .depth_p(4), .ecode_width_p(4)) u_if ();

   bp_be_issue_queue #(.vaddr_width_p(39), .depth_p(4), .ecode_width_p(4)) u_dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus_io    (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      u_if.fe_v_i         = 1'b0;
      u_if.fe_exc_v_i     = 1'b0;
      u_if.fe_exc_code_i  = '0;
      u_if.fe_pc_i        = '0;
      u_if.fe_instr_i     = '0;
      u_if.dispatch_v_i   = 1'b0;
      u_if.expected_npc_i = '0;
      u_if.poison_i       = 1'b0;
      u_if.flush_i        = 1'b0;
   endtask

   task automatic drive_fe(input logic exc, input logic [3:0] code, input logic [38:0] pc,
                           input logic [31:0] instr);
      u_if.fe_v_i        = 1'b1;
      u_if.fe_exc_v_i    = exc;
      u_if.fe_exc_code_i = code;
      u_if.fe_pc_i       = pc;
      u_if.fe_instr_i    = instr;
   endtask

   // Enqueue one instruction with no dispatch, one cycle
   task automatic enq(input logic [38:0] pc, input logic [31:0] instr);
      idle();
      drive_fe(1'b0, 4'd0, pc, instr);
      step();
      idle();
   endtask

   task automatic test_reset();
      drive_fe(1'b0, 4'd0, 39'h1000, 32'h00500093);
      u_if.dispatch_v_i = 1'b1;
      #1;
      checks++;
      if (u_if.fe_yumi_o !== 1'b0) begin
         errors++; $display("FAIL reset_yumi: got %0b exp 0", u_if.fe_yumi_o);
      end
      checks++;
      if (u_if.isd_v_o !== 1'b0) begin
         errors++; $display("FAIL reset_isd_v: got %0b exp 0", u_if.isd_v_o);
      end
      step();
      idle();
      reset_n = 1'b1;
      #1;
      checks++;
      if (u_if.count_o !== 3'd0) begin
         errors++; $display("FAIL reset_count: got %0d exp 0", u_if.count_o);
      end
      checks++;
      if (u_if.isd_irs1_v_o !== 1'b0) begin
         errors++; $display("FAIL reset_irs1: got %0b exp 0", u_if.isd_irs1_v_o);
      end
   endtask

   task automatic test_fill();
      logic [31:0] addi [5];
      addi[0] = 32'h00500093; addi[1] = 32'hFFF00093; addi[2] = 32'h7FF00093;
      addi[3] = 32'h80000093; addi[4] = 32'h00100093;
      for (int i = 0; i < 5; i++) begin
         idle();
         drive_fe(1'b0, 4'd0, 39'(32'h1000 + 4 * i), addi[i]);
         #1;
         checks++;
         if (u_if.fe_yumi_o !== 1'(i < 4)) begin
            errors++; $display("FAIL fill_yumi[%0d]: got %0b exp %0b", i, u_if.fe_yumi_o, i < 4);
         end
         checks++;
         if (u_if.count_o !== 3'(i < 4 ? i : 4)) begin
            errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, u_if.count_o,
                               (i < 4 ? i : 4));
         end
         step();
      end
      idle();
      #1;
      checks++;
      if (u_if.count_o !== 3'd4) begin
         errors++; $display("FAIL fill_full_count: got %0d exp 4", u_if.count_o);
      end
      checks++;
      if (u_if.isd_pc_o !== 39'h1000) begin
         errors++; $display("FAIL fill_head_pc: got %h exp 1000", u_if.isd_pc_o);
      end
      checks++;
      if (u_if.isd_irs1_v_o !== 1'b1 || u_if.isd_irs2_v_o !== 1'b0) begin
         errors++; $display("FAIL fill_rs_v: got %0b%0b exp 10", u_if.isd_irs1_v_o,
                            u_if.isd_irs2_v_o);
      end
      checks++;
      if (u_if.isd_imm_o !== 64'd5) begin
         errors++; $display("FAIL fill_imm: got %h exp 5", u_if.isd_imm_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_imm [4];
      logic [63:0] e_imm;
      exp_imm[0] = 64'd5;
      exp_imm[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_imm[2] = 64'h7FF;
      exp_imm[3] = 64'hFFFF_FFFF_FFFF_F800;
      for (int k = 0; k < 6; k++) begin
         idle();
         drive_fe(1'b0, 4'd0, 39'(32'h1010 + 4 * k), 32'h00000093 | (32'(k) << 20));
         u_if.dispatch_v_i   = 1'b1;
         u_if.expected_npc_i = 39'(32'h1000 + 4 * k);
         #1;
         e_imm = (k < 4) ? exp_imm[k] : 64'(k - 4);
         checks++;
         if (u_if.fe_yumi_o !== 1'b1 || u_if.isd_v_o !== 1'b1) begin
            errors++; $display("FAIL b2b_hs[%0d]: got yumi %0b isd_v %0b exp 1 1", k,
                               u_if.fe_yumi_o, u_if.isd_v_o);
         end
         checks++;
         if (u_if.isd_pc_o !== 39'(32'h1000 + 4 * k)) begin
            errors++; $display("FAIL b2b_pc[%0d]: got %h exp %h", k, u_if.isd_pc_o,
                               32'h1000 + 4 * k);
         end
         checks++;
         if (u_if.isd_poison_o !== 1'b0) begin
            errors++; $display("FAIL b2b_poison[%0d]: got %0b exp 0", k, u_if.isd_poison_o);
         end
         checks++;
         if (u_if.count_o !== 3'd4) begin
            errors++; $display("FAIL b2b_count[%0d]: got %0d exp 4", k, u_if.count_o);
         end
         checks++;
         if (u_if.isd_imm_o !== e_imm) begin
            errors++; $display("FAIL b2b_imm[%0d]: got %h exp %h", k, u_if.isd_imm_o, e_imm);
         end
         step();
      end
      idle();
      #1;
      checks++;
      if (u_if.count_o !== 3'd4 || u_if.isd_pc_o !== 39'h1018) begin
         errors++; $display("FAIL b2b_end: got count %0d pc %h exp 4 1018", u_if.count_o,
                            u_if.isd_pc_o);
      end
   endtask

   task automatic test_npc_mismatch();
      idle();
      u_if.flush_i = 1'b1;
      step();
      enq(39'h1008, 32'h00500093);
      enq(39'h100C, 32'h00500093);
      u_if.dispatch_v_i   = 1'b1;
      u_if.expected_npc_i = 39'h1010;
      #1;
      checks++;
      if (u_if.isd_v_o !== 1'b1 || u_if.isd_poison_o !== 1'b1) begin
         errors++; $display("FAIL npc_mismatch: got v %0b poison %0b exp 1 1", u_if.isd_v_o,
                            u_if.isd_poison_o);
      end
      step();
      u_if.expected_npc_i = 39'h100C;
      #1;
      checks++;
      if (u_if.isd_v_o !== 1'b1 || u_if.isd_poison_o !== 1'b0) begin
         errors++; $display("FAIL npc_match: got v %0b poison %0b exp 1 0", u_if.isd_v_o,
                            u_if.isd_poison_o);
      end
      step();
      idle();
   endtask

   task automatic test_poison_flush();
      for (int i = 0; i < 4; i++) enq(39'(32'h3000 + 4 * i), 32'h00500093);
      u_if.poison_i = 1'b1;
      #1;
      checks++;
      if (u_if.isd_v_o !== 1'b0 || u_if.isd_poison_o !== 1'b0) begin
         errors++; $display("FAIL poison_no_dispatch: got v %0b poison %0b exp 0 0",
                            u_if.isd_v_o, u_if.isd_poison_o);
      end
      step();
      idle();
      for (int j = 0; j < 3; j++) begin
         u_if.dispatch_v_i   = 1'b1;
         u_if.expected_npc_i = 39'(32'h3000 + 4 * j);
         #1;
         checks++;
         if (u_if.isd_v_o !== 1'b1 || u_if.isd_poison_o !== 1'b1) begin
            errors++; $display("FAIL poison_sticky[%0d]: got v %0b poison %0b exp 1 1", j,
                               u_if.isd_v_o, u_if.isd_poison_o);
         end
         step();
      end
      idle();
      u_if.flush_i = 1'b1;
      step();
      idle();
      #1;
      checks++;
      if (u_if.count_o !== 3'd0) begin
         errors++; $display("FAIL poison_flush_count: got %0d exp 0", u_if.count_o);
      end
      enq(39'h4000, 32'h00500093);
      u_if.dispatch_v_i   = 1'b1;
      u_if.expected_npc_i = 39'h4000;
      #1;
      checks++;
      if (u_if.isd_v_o !== 1'b1 || u_if.isd_poison_o !== 1'b0) begin
         errors++; $display("FAIL poison_cleared: got v %0b poison %0b exp 1 0", u_if.isd_v_o,
                            u_if.isd_poison_o);
      end
      step();
      idle();
   endtask

   task automatic test_flush_concurrent();
      enq(39'h5000, 32'h00500093);
      enq(39'h5004, 32'h00500093);
      drive_fe(1'b0, 4'd0, 39'h5008, 32'h00500093);
      u_if.dispatch_v_i   = 1'b1;
      u_if.expected_npc_i = 39'h5000;
      u_if.flush_i        = 1'b1;
      #1;
      checks++;
      if (u_if.fe_yumi_o !== 1'b0 || u_if.isd_v_o !== 1'b0) begin
         errors++; $display("FAIL flush_hs: got yumi %0b isd_v %0b exp 0 0", u_if.fe_yumi_o,
                            u_if.isd_v_o);
      end
      step();
      idle();
      u_if.dispatch_v_i = 1'b1;
      #1;
      checks++;
      if (u_if.count_o !== 3'd0 || u_if.isd_v_o !== 1'b0) begin
         errors++; $display("FAIL flush_empty: got count %0d isd_v %0b exp 0 0", u_if.count_o,
                            u_if.isd_v_o);
      end
      step();
      idle();
   endtask

   task automatic test_reset_mid();
      enq(39'h6000, 32'h00500093);
      enq(39'h6004, 32'h00500093);
      reset_n = 1'b0;
      drive_fe(1'b0, 4'd0, 39'h6008, 32'h00500093);
      u_if.dispatch_v_i   = 1'b1;
      u_if.expected_npc_i = 39'h6000;
      #1;
      checks++;
      if (u_if.isd_v_o !== 1'b0 || u_if.fe_yumi_o !== 1'b0 || u_if.count_o !== 3'd0) begin
         errors++; $display("FAIL midreset_outs: got v %0b yumi %0b count %0d exp 0 0 0",
                            u_if.isd_v_o, u_if.fe_yumi_o, u_if.count_o);
      end
      step();
      reset_n = 1'b1;
      idle();
      #1;
      checks++;
      if (u_if.count_o !== 3'd0) begin
         errors++; $display("FAIL midreset_count: got %0d exp 0", u_if.count_o);
      end
   endtask

   task automatic test_predecode();
      logic [38:0] pcs [4];
      logic        e_exc [4], e_mem [4], e_fence [4], e_rs1 [4], e_rs2 [4];
      logic [63:0] e_imm [4];
      pcs[0] = 39'h2000; pcs[1] = 39'h2004; pcs[2] = 39'h2008; pcs[3] = 39'h200C;
      e_exc[0] = 1'b1; e_mem[0] = 1'b0; e_fence[0] = 1'b0; e_rs1[0] = 1'b0; e_rs2[0] = 1'b0;
      e_exc[1] = 1'b0; e_mem[1] = 1'b1; e_fence[1] = 1'b0; e_rs1[1] = 1'b1; e_rs2[1] = 1'b1;
      e_exc[2] = 1'b0; e_mem[2] = 1'b0; e_fence[2] = 1'b1; e_rs1[2] = 1'b0; e_rs2[2] = 1'b0;
      e_exc[3] = 1'b0; e_mem[3] = 1'b0; e_fence[3] = 1'b0; e_rs1[3] = 1'b1; e_rs2[3] = 1'b1;
      e_imm[0] = 64'd0;
      e_imm[1] = 64'hFFFF_FFFF_FFFF_FFF8;
      e_imm[2] = 64'd0;
      e_imm[3] = 64'hFFFF_FFFF_FFFF_FFFC;
      // Exception carries a store-looking word to prove predecode is suppressed
      idle();
      drive_fe(1'b1, 4'd2, 39'h2000, 32'hFE112C23);
      step();
      enq(39'h2004, 32'hFE112C23);
      enq(39'h2008, 32'h0FF0000F);
      enq(39'h200C, 32'hFE208EE3);
      for (int j = 0; j < 4; j++) begin
         u_if.dispatch_v_i   = 1'b1;
         u_if.expected_npc_i = pcs[j];
         #1;
         checks++;
         if (u_if.isd_pc_o !== pcs[j] || u_if.isd_exc_v_o !== e_exc[j]) begin
            errors++; $display("FAIL pd_pc_exc[%0d]: got pc %h exc %0b exp %h %0b", j,
                               u_if.isd_pc_o, u_if.isd_exc_v_o, pcs[j], e_exc[j]);
         end
         checks++;
         if (u_if.isd_mem_v_o !== e_mem[j] || u_if.isd_fence_v_o !== e_fence[j]
             || u_if.isd_irs1_v_o !== e_rs1[j] || u_if.isd_irs2_v_o !== e_rs2[j]) begin
            errors++; $display("FAIL pd_bits[%0d]: got mfr12 %0b%0b%0b%0b exp %0b%0b%0b%0b", j,
                               u_if.isd_mem_v_o, u_if.isd_fence_v_o, u_if.isd_irs1_v_o,
                               u_if.isd_irs2_v_o, e_mem[j], e_fence[j], e_rs1[j], e_rs2[j]);
         end
         checks++;
         if (u_if.isd_imm_o !== e_imm[j]) begin
            errors++; $display("FAIL pd_imm[%0d]: got %h exp %h", j, u_if.isd_imm_o, e_imm[j]);
         end
         if (j == 0) begin
            checks++;
            if (u_if.isd_exc_code_o !== 4'd2) begin
               errors++; $display("FAIL pd_exc_code: got %0d exp 2", u_if.isd_exc_code_o);
            end
         end
         step();
      end
      idle();
      #1;
      checks++;
      if (u_if.isd_irs1_v_o !== 1'b0 || u_if.count_o !== 3'd0) begin
         errors++; $display("FAIL pd_drained: got irs1 %0b count %0d exp 0 0",
                            u_if.isd_irs1_v_o, u_if.count_o);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      step();
      step();
      test_reset();
      test_fill();
      test_back_to_back();
      test_npc_mismatch();
      test_poison_flush();
      test_flush_concurrent();
      test_reset_mid();
      test_predecode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
